activation_column_pipe: RTL and testbench

- Parametrised, pipelined successor to the purely combinational per-column ReLU stage.
- Applies a runtime-selectable activation to one column of COLUMN_SIZE signed fixed-point values per beat: bypass, ReLU, leaky ReLU or clamped ReLU (ReLU-N).
- Sits between the convolution accumulator column output and the pooling/feature-map writer.
- Adds valid/ready backpressure and column/frame framing (out_last).

---
 rtl/activation_column_pipe_if.sv | 33 +++
 rtl/activation_column_pipe.sv | 79 +++++++
 tb/tb_activation_column_pipe.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/activation_column_pipe_if.sv
// activation_column_pipe_if: column stream bundle (input beat with mode/cap, output beat with framing).
// ACT_COLUMN_STATS_EN adds the zero_count sparsity output.
interface activation_column_pipe_if #(
   parameter int COLUMN_SIZE = 24,
   parameter int DATA_WIDTH = 16
);
   logic in_valid;
   logic in_ready;
   logic [COLUMN_SIZE-1:0][DATA_WIDTH-1:0] in_data;
   logic [1:0] mode;
   logic [DATA_WIDTH-1:0] cap;
   logic out_valid;
   logic out_ready;
   logic [COLUMN_SIZE-1:0][DATA_WIDTH-1:0] out_data;
   logic out_last;
`ifdef ACT_COLUMN_STATS_EN
   logic [$clog2(COLUMN_SIZE+1)-1:0] zero_count;
`endif
   modport master (
      output in_valid, in_data, mode, cap, out_ready,
      input in_ready, out_valid, out_data, out_last
`ifdef ACT_COLUMN_STATS_EN
      , zero_count
`endif
   );
   modport slave (
      input in_valid, in_data, mode, cap, out_ready,
      output in_ready, out_valid, out_data, out_last
`ifdef ACT_COLUMN_STATS_EN
      , zero_count
`endif
   );
endinterface

// File: rtl/activation_column_pipe.sv
// activation_column_pipe: 2-stage column activation (bypass/ReLU/leaky/clamp) with backpressure and framing.
// ACT_COLUMN_STATS_EN adds a registered per-beat zero_count.
module activation_column_pipe #(
   parameter int COLUMN_SIZE = 24,
   parameter int DATA_WIDTH = 16,
   parameter int LEAK_SHIFT = 3,
   parameter int FRAME_COLUMNS = 24
) (
   input logic clk,
   input logic rst,
   activation_column_pipe_if.slave bus
);
   localparam int CW = FRAME_COLUMNS > 1 ? $clog2(FRAME_COLUMNS) : 1;
   typedef logic [COLUMN_SIZE-1:0][DATA_WIDTH-1:0] col_t;
   logic [CW-1:0] cnt;
   logic cnt_last;
   logic s1_valid;
   logic s1_last;
   col_t s1_x;
   col_t s1_leak;
   logic [COLUMN_SIZE-1:0] s1_neg;
   logic [1:0] s1_mode;
   logic [DATA_WIDTH-1:0] s1_cap;
   col_t leak;
   col_t y;
   logic [COLUMN_SIZE-1:0] neg;
   logic s2_adv;
   logic in_fire;
   assign s2_adv = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = !s1_valid || s2_adv;
   assign in_fire = bus.in_valid && bus.in_ready;
   assign cnt_last = cnt == CW'(FRAME_COLUMNS - 1);
   always_comb begin
      for (int i = 0; i < COLUMN_SIZE; i++) begin
         neg[i] = bus.in_data[i][DATA_WIDTH-1];
         leak[i] = $signed(bus.in_data[i]) >>> LEAK_SHIFT;
         y[i] = s1_mode == 2'd0 ? s1_x[i] :
                s1_neg[i] ? (s1_mode == 2'd2 ? s1_leak[i] : '0) :
                (s1_mode == 2'd3 && $signed(s1_x[i]) > $signed(s1_cap)) ? s1_cap : s1_x[i];
      end
   end
`ifdef ACT_COLUMN_STATS_EN
   localparam int ZW = $clog2(COLUMN_SIZE + 1);
   logic [ZW-1:0] zc;
   always_comb begin
      zc = '0;
      for (int i = 0; i < COLUMN_SIZE; i++) zc = zc + ZW'(y[i] == '0);
   end
   always_ff @(posedge clk) begin
      if (rst) bus.zero_count <= '0;
      else if (s2_adv && s1_valid) bus.zero_count <= zc;
   end
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         cnt <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data <= '0;
         bus.out_last <= 1'b0;
      end else begin
         if (bus.in_ready) s1_valid <= bus.in_valid;
         if (in_fire) begin
            s1_x <= bus.in_data;
            s1_leak <= leak;
            s1_neg <= neg;
            s1_mode <= bus.mode;
            s1_cap <= bus.cap[DATA_WIDTH-1] ? '0 : bus.cap;
            s1_last <= cnt_last;
            cnt <= cnt_last ? '0 : CW'(cnt + 1'b1);
         end
         if (s2_adv) bus.out_valid <= s1_valid;
         if (s2_adv && s1_valid) begin
            bus.out_data <= y;
            bus.out_last <= s1_last;
         end
      end
   end
endmodule

// File: tb/tb_activation_column_pipe.sv
// tb_activation_column_pipe: scoreboard bench; expected columns come from an integer floor-division model.
module tb_activation_column_pipe;
   localparam int C = 24;
   localparam int W = 16;
   localparam int LS = 3;
   localparam int F = 4;
   typedef logic [C-1:0][W-1:0] col_t;
   typedef struct {
      col_t d;
      logic l;
      int z;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   activation_column_pipe_if #(.COLUMN_SIZE(C), .DATA_WIDTH(W)) bus();
   activation_column_pipe #(.COLUMN_SIZE(C), .DATA_WIDTH(W), .LEAK_SHIFT(LS), .FRAME_COLUMNS(F)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   int checks = 0;
   int failures = 0;
   exp_t q[$];
   int mcnt = 0;
   logic stall = 1'b0;
   col_t held_d;
   logic held_l;
   logic bp_en = 1'b0;
   int ph = 0;
   int pv[$];

   task automatic check(input string tag, input logic [C*W-1:0] got, input logic [C*W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic col_t model(input col_t d, input logic [1:0] m, input logic [W-1:0] c);
      col_t r;
      int cp;
      int x;
      int y;
      int fl;
      cp = $signed(c) < 0 ? 0 : int'($signed(c));
      for (int i = 0; i < C; i++) begin
         x = int'($signed(d[i]));
         fl = x / (1 << LS);
         if (x < 0 && fl * (1 << LS) != x) fl = fl - 1;
         if (m == 2'd0) y = x;
         else if (m == 2'd1) y = x < 0 ? 0 : x;
         else if (m == 2'd2) y = x < 0 ? fl : x;
         else y = x < 0 ? 0 : (x > cp ? cp : x);
         r[i] = W'(y);
      end
      return r;
   endfunction

   function automatic int zeros(input col_t d);
      int n = 0;
      for (int i = 0; i < C; i++) if (d[i] == '0) n++;
      return n;
   endfunction

   function automatic col_t fill(input int v[$]);
      col_t r;
      for (int i = 0; i < C; i++) r[i] = W'(v[i % v.size()]);
      return r;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
         mcnt = 0;
         stall = 1'b0;
      end else begin
         check("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
         if (stall) begin
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_data", bus.out_data, held_d);
            check("hold_last", bus.out_last, held_l);
         end
         stall = bus.out_valid && !bus.out_ready;
         held_d = bus.out_data;
         held_l = bus.out_last;
         if (bus.in_valid && bus.in_ready) begin
            e.d = model(bus.in_data, bus.mode, bus.cap);
            e.l = mcnt == F - 1;
            e.z = zeros(e.d);
            q.push_back(e);
            mcnt = mcnt == F - 1 ? 0 : mcnt + 1;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) check("spurious_out", 1'b1, 1'b0);
            else begin
               e = q.pop_front();
               check("out_data", bus.out_data, e.d);
               check("out_last", bus.out_last, e.l);
`ifdef ACT_COLUMN_STATS_EN
               check("zero_count", C*W'(bus.zero_count), C*W'(e.z));
`endif
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (bp_en) begin
         bus.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
         ph++;
      end
   end

   task automatic send(input col_t d, input logic [1:0] m, input logic [W-1:0] c);
      int t = 0;
      logic ok;
      bus.in_valid = 1'b1;
      bus.in_data = d;
      bus.mode = m;
      bus.cap = c;
      do begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!ok && t < 200);
      if (!ok) check("send_timeout", 1'b0, 1'b1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() > 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("drain_empty", q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.mode = 2'd0;
      bus.cap = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_valid", bus.out_valid, 1'b0);
      check("reset_last", bus.out_last, 1'b0);
      check("reset_data", bus.out_data, '0);
`ifdef ACT_COLUMN_STATS_EN
      check("reset_zc", C*W'(bus.zero_count), '0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
      pv = '{-5, 0, 7, 32767, -32768};
      send(fill(pv), 2'd1, '0);
      @(negedge clk);
      check("latency_early", bus.out_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("latency_valid", bus.out_valid, 1'b1);
      drain();
      pv = '{-8, -9, -1, 100};
      send(fill(pv), 2'd2, '0);
      pv = '{2000, 1536, 500, -3};
      send(fill(pv), 2'd3, 16'd1536);
      send(fill(pv), 2'd3, 16'hFFFC);
      drain();
      bp_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         col_t d;
         for (int i = 0; i < C; i++) d[i] = W'($urandom);
         send(d, 2'(k), W'($urandom_range(0, 3000)));
      end
      drain();
      bp_en = 1'b0;
      bus.out_ready = 1'b1;
      do_reset();
      pv.delete();
      for (int i = 0; i < C; i++) pv.push_back(i < 10 ? -3 - i : (i < 12 ? 0 : i));
      for (int k = 0; k < 9; k++) send(k == 0 ? fill(pv) : col_t'({C{W'(k * 37 - 150)}}), 2'(k), 16'd100);
      drain();
      for (int k = 0; k < 6; k++) send(col_t'({C{W'(k * 11 - 20)}}), 2'd1, '0);
      do_reset();
      for (int k = 0; k < 4; k++) send(col_t'({C{W'(k * 5 - 7)}}), 2'd2, '0);
      drain();
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
